// File: rtl/polyphase_pkg.sv
// Shared definitions for the 2-branch polyphase analysis/synthesis filters:
// default widths, FSM state encoding and saturation helpers.
package polyphase_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_COEFF_WIDTH = 16;
    localparam int DEF_NOF_TAPS    = 4;
    localparam int DEF_COEFF_FRAC  = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_ADD  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_MUL  = ST_MUL,
        S_ADD  = ST_ADD,
        S_OUT  = ST_OUT
    } state_t;

    // Largest / smallest representable value of a signed w-bit sample.
    function automatic int sat_max(input int w);
        return (1 <<< (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 <<< (w - 1));
    endfunction

    localparam int SAT_MAX = sat_max(DEF_DATA_WIDTH);
    localparam int SAT_MIN = sat_min(DEF_DATA_WIDTH);

endpackage

// File: rtl/polyphase_tap_mac.sv
// Per-branch multiply-accumulate: registered tap products, adder tree,
// arithmetic shift back to sample scale and saturation into a result register.
module polyphase_tap_mac
    import polyphase_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int NOF_TAPS    = DEF_NOF_TAPS,
    parameter int COEFF_FRAC  = DEF_COEFF_FRAC
) (
    input  logic                                 clk_data,
    input  logic                                 rst,
    input  logic [NOF_TAPS-1:0][DATA_WIDTH-1:0]  line,
    input  logic [NOF_TAPS*COEFF_WIDTH-1:0]      coeff,
    input  logic                                 mul_en,
    input  logic                                 add_en,
    output logic signed [DATA_WIDTH-1:0]         result
);

    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    // Two guard bits cover the default four taps; wider trees grow with clog2.
    localparam int GUARD  = ($clog2(NOF_TAPS) > 2) ? $clog2(NOF_TAPS) : 2;
    localparam int SUM_W  = PROD_W + GUARD;

    localparam logic signed [SUM_W-1:0] MAX_EXT = SUM_W'(sat_max(DATA_WIDTH));
    localparam logic signed [SUM_W-1:0] MIN_EXT = SUM_W'(sat_min(DATA_WIDTH));

    logic signed [COEFF_WIDTH-1:0] coeff_tap [NOF_TAPS];
    logic signed [PROD_W-1:0]      prod_next [NOF_TAPS];
    logic signed [PROD_W-1:0]      prod_reg  [NOF_TAPS];
    logic signed [SUM_W-1:0]       sum;
    logic signed [SUM_W-1:0]       shifted;
    logic signed [DATA_WIDTH-1:0]  sat_value;
    logic signed [DATA_WIDTH-1:0]  result_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NOF_TAPS; gi++) begin : g_tap
            assign coeff_tap[gi] = coeff[gi*COEFF_WIDTH +: COEFF_WIDTH];
            assign prod_next[gi] = $signed(line[gi]) * coeff_tap[gi];
        end
    endgenerate

    // Capture all tap products in the multiply cycle.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            for (int k = 0; k < NOF_TAPS; k++) prod_reg[k] <= '0;
        end else if (mul_en) begin
            for (int k = 0; k < NOF_TAPS; k++) prod_reg[k] <= prod_next[k];
        end
    end

    // Sum the sign-extended products, drop the fraction, clamp to sample range.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NOF_TAPS; k++) sum = sum + SUM_W'(prod_reg[k]);
        shifted = sum >>> COEFF_FRAC;
        if (shifted > MAX_EXT)      sat_value = DATA_WIDTH'(MAX_EXT);
        else if (shifted < MIN_EXT) sat_value = DATA_WIDTH'(MIN_EXT);
        else                        sat_value = shifted[DATA_WIDTH-1:0];
    end

    // Hold the saturated result until the next add cycle.
    always_ff @(posedge clk_data) begin
        if (rst)         result_reg <= '0;
        else if (add_en) result_reg <= sat_value;
    end

    assign result = result_reg;

endmodule

// File: rtl/polyphase_interpolator.sv
// 2-branch polyphase synthesis filter (interpolate by 2): each accepted sample
// produces a phase-0 then a phase-1 output through a shared MAC.
module polyphase_interpolator
    import polyphase_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int NOF_TAPS    = DEF_NOF_TAPS,
    parameter int COEFF_FRAC  = DEF_COEFF_FRAC
) (
    input  logic                            clk_data,
    input  logic                            rst,
    input  logic signed [DATA_WIDTH-1:0]    s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NOF_TAPS*COEFF_WIDTH-1:0] coeff_ph0,
    input  logic [NOF_TAPS*COEFF_WIDTH-1:0] coeff_ph1,
    output logic signed [DATA_WIDTH-1:0]    m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            m_phase
);

    state_t state_reg, state_next;
    logic   phase_reg, phase_next;
    logic   m_phase_reg;
    logic   shift_en, mul_en, add_en;

    logic [NOF_TAPS-1:0][DATA_WIDTH-1:0] line_reg;
    logic [NOF_TAPS*COEFF_WIDTH-1:0]     coeff_sel;

    // State and phase registers.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            state_reg <= S_IDLE;
            phase_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
        end
    end

    // Next-state logic and handshake/strobe decode.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        shift_en   = 1'b0;
        mul_en     = 1'b0;
        add_en     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    shift_en   = 1'b1;
                    phase_next = 1'b0;
                    state_next = S_MUL;
                end
            end
            S_MUL: begin
                mul_en     = 1'b1;
                state_next = S_ADD;
            end
            S_ADD: begin
                add_en     = 1'b1;
                state_next = S_OUT;
            end
            S_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (!phase_reg) begin
                        phase_next = 1'b1;
                        state_next = S_MUL;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Delay line: newest sample enters at tap 0 on every accept.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            line_reg <= '0;
        end else if (shift_en) begin
            line_reg[0] <= s_data;
            for (int k = 1; k < NOF_TAPS; k++) line_reg[k] <= line_reg[k-1];
        end
    end

    // The phase tag travels with the result it labels.
    always_ff @(posedge clk_data) begin
        if (rst)         m_phase_reg <= 1'b0;
        else if (add_en) m_phase_reg <= phase_reg;
    end

    assign coeff_sel = phase_reg ? coeff_ph1 : coeff_ph0;

    polyphase_tap_mac #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .NOF_TAPS    (NOF_TAPS),
        .COEFF_FRAC  (COEFF_FRAC)
    ) u_mac (
        .clk_data (clk_data),
        .rst      (rst),
        .line     (line_reg),
        .coeff    (coeff_sel),
        .mul_en   (mul_en),
        .add_en   (add_en),
        .result   (m_data)
    );

    assign m_phase = m_phase_reg;

endmodule

// File: tb/tb_polyphase_interpolator.sv
// Self-checking bench for polyphase_interpolator: vector table, hand-written
// handshake/reset/coefficient sequences and a randomized model comparison.
module tb_polyphase_interpolator;
    import polyphase_pkg::*;

    logic               clk_data = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [63:0]        coeff_ph0 = '0;
    logic [63:0]        coeff_ph1 = '0;
    logic signed [15:0] m_data;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic               m_phase;

    int total = 0;
    int bad   = 0;

    polyphase_interpolator dut (
        .clk_data  (clk_data),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .coeff_ph0 (coeff_ph0),
        .coeff_ph1 (coeff_ph1),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_phase   (m_phase)
    );

    always #5 clk_data = ~clk_data;

    typedef struct {
        logic        do_reset;
        logic [63:0] c0;
        logic [63:0] c1;
        int          sample;
        int          exp0;
        int          exp1;
    } vec_t;

    vec_t vecs [12];
    int   model_line [4];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Reference: dot product of history and coefficients, floor by 2^15, clamp.
    function automatic int ref_out(input logic [63:0] cb);
        longint acc = 0;
        logic signed [15:0] c;
        for (int k = 0; k < 4; k++) begin
            c = cb[k*16 +: 16];
            acc += longint'(model_line[k]) * longint'(c);
        end
        acc = acc >>> 15;
        if (acc > SAT_MAX) acc = SAT_MAX;
        if (acc < SAT_MIN) acc = SAT_MIN;
        return int'(acc);
    endfunction

    function automatic void model_push(input int s);
        for (int k = 3; k > 0; k--) model_line[k] = model_line[k-1];
        model_line[0] = s;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 4; k++) model_line[k] = 0;
    endfunction

    task automatic do_reset();
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst     = 1'b1;
        @(posedge clk_data); #1;
        rst     = 1'b0;
    endtask

    // Cycles until m_valid rises (sampled 1 time unit after each edge).
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!m_valid && cnt < 40) begin
            @(posedge clk_data); #1;
            cnt++;
        end
        if (!m_valid) check("valid_timeout", 0, 1);
    endtask

    // One full transaction: accept a sample, check both phases with stalls.
    task automatic send(input int sample, input int exp0, input int exp1,
                        input int stall0, input int stall1, input string name);
        int cnt;
        cnt = 0;
        while (!s_ready && cnt < 40) begin
            @(posedge clk_data); #1;
            cnt++;
        end
        if (!s_ready) check({name, "_ready_timeout"}, 0, 1);
        s_valid = 1'b1;
        s_data  = 16'(sample);
        @(posedge clk_data); #1;
        s_valid = 1'b0;
        wait_valid(cnt);
        check({name, "_lat0"}, cnt, 2);
        check({name, "_ph0"}, m_data, exp0);
        check({name, "_tag0"}, m_phase, 0);
        repeat (stall0) begin
            @(posedge clk_data); #1;
            check({name, "_hold0"}, m_data, exp0);
        end
        m_ready = 1'b1;
        @(posedge clk_data); #1;
        m_ready = 1'b0;
        wait_valid(cnt);
        check({name, "_lat1"}, cnt + 1, 3);
        check({name, "_ph1"}, m_data, exp1);
        check({name, "_tag1"}, m_phase, 1);
        repeat (stall1) begin
            @(posedge clk_data); #1;
            check({name, "_hold1"}, m_data, exp1);
        end
        m_ready = 1'b1;
        @(posedge clk_data); #1;
        m_ready = 1'b0;
        check({name, "_idle"}, s_ready, 1);
        $display("txn %s: in=%0d out0=%0d out1=%0d", name, sample, exp0, exp1);
    endtask

    initial begin
        logic [63:0] imp0, imp1, sat_c;
        logic [19:0] acc_mask, val_mask, ph_mask, exp_acc, exp_val, exp_ph;
        int cnt, e0, e1, smp;

        imp0  = pack4(16384, 8192, 4096, 2048);
        imp1  = pack4(-16384, -8192, -4096, -2048);
        sat_c = pack4(32767, 32767, 32767, 32767);

        vecs[0]  = '{1'b1, imp0, imp1, 1000, 500, -500};
        vecs[1]  = '{1'b0, imp0, imp1, 0, 250, -250};
        vecs[2]  = '{1'b0, imp0, imp1, 0, 125, -125};
        vecs[3]  = '{1'b0, imp0, imp1, 0, 62, -63};
        vecs[4]  = '{1'b1, sat_c, sat_c, 32767, 32766, 32766};
        vecs[5]  = '{1'b0, sat_c, sat_c, 32767, 32767, 32767};
        vecs[6]  = '{1'b0, sat_c, sat_c, 32767, 32767, 32767};
        vecs[7]  = '{1'b0, sat_c, sat_c, 32767, 32767, 32767};
        vecs[8]  = '{1'b1, sat_c, sat_c, -32768, -32767, -32767};
        vecs[9]  = '{1'b0, sat_c, sat_c, -32768, -32768, -32768};
        vecs[10] = '{1'b0, sat_c, sat_c, -32768, -32768, -32768};
        vecs[11] = '{1'b0, sat_c, sat_c, -32768, -32768, -32768};

        // Reset state and idle without input
        repeat (3) @(posedge clk_data);
        #1;
        rst = 1'b0;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_phase", m_phase, 0);
        cnt = 0;
        repeat (10) begin
            @(posedge clk_data); #1;
            if (m_valid) cnt++;
        end
        check("idle_no_output", cnt, 0);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_reset) do_reset();
            coeff_ph0 = vecs[i].c0;
            coeff_ph1 = vecs[i].c1;
            send(vecs[i].sample, vecs[i].exp0, vecs[i].exp1, i % 3, (i + 1) % 3,
                 $sformatf("vec%0d", i));
        end

        // Backpressure: five stalled cycles in phase-0 output
        do_reset();
        coeff_ph0 = imp0;
        coeff_ph1 = imp1;
        s_valid = 1'b1;
        s_data  = 16'sd1000;
        @(posedge clk_data); #1;
        s_valid = 1'b0;
        wait_valid(cnt);
        repeat (5) begin
            @(posedge clk_data); #1;
            check("bp_valid", m_valid, 1);
            check("bp_data", m_data, 500);
            check("bp_phase", m_phase, 0);
            check("bp_s_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        @(posedge clk_data); #1;
        m_ready = 1'b0;
        wait_valid(cnt);
        check("bp_lat1", cnt + 1, 3);
        check("bp_ph1", m_data, -500);
        m_ready = 1'b1;
        @(posedge clk_data); #1;
        m_ready = 1'b0;
        $display("txn backpressure: stalled 5 cycles");

        // Throughput with continuous s_valid and m_ready
        do_reset();
        s_valid = 1'b1;
        s_data  = 16'sd100;
        m_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            acc_mask[k] = s_valid && s_ready;
            val_mask[k] = m_valid;
            ph_mask[k]  = m_valid && m_phase;
            exp_acc[k]  = (k % 7 == 0);
            exp_val[k]  = (k % 7 == 3) || (k % 7 == 6);
            exp_ph[k]   = (k % 7 == 6);
            @(posedge clk_data); #1;
        end
        check("tp_accepts", acc_mask, exp_acc);
        check("tp_valids", val_mask, exp_val);
        check("tp_phases", ph_mask, exp_ph);
        $display("txn throughput: accepts=%b valids=%b", acc_mask, val_mask);

        // Reset while holding a phase-0 output
        do_reset();
        coeff_ph0 = imp0;
        coeff_ph1 = imp1;
        send(1000, 500, -500, 0, 0, "pre_rst");
        s_valid = 1'b1;
        s_data  = 16'sd0;
        @(posedge clk_data); #1;
        s_valid = 1'b0;
        wait_valid(cnt);
        check("midop_ph0", m_data, 250);
        rst = 1'b1;
        @(posedge clk_data); #1;
        rst = 1'b0;
        check("midop_m_valid", m_valid, 0);
        check("midop_s_ready", s_ready, 1);
        check("midop_m_data", m_data, 0);
        check("midop_m_phase", m_phase, 0);
        send(1000, 500, -500, 1, 0, "post_rst");

        // Coefficient timing around phase-1 multiply
        do_reset();
        coeff_ph0 = imp0;
        coeff_ph1 = imp1;
        s_valid = 1'b1;
        s_data  = 16'sd1000;
        @(posedge clk_data); #1;
        s_valid = 1'b0;
        wait_valid(cnt);
        check("ct_ph0", m_data, 500);
        coeff_ph1 = pack4(-8192, -8192, -4096, -2048);
        m_ready = 1'b1;
        @(posedge clk_data); #1;
        m_ready = 1'b0;
        wait_valid(cnt);
        check("ct_ph1_new", m_data, -250);
        coeff_ph1 = pack4(-32768, 0, 0, 0);
        coeff_ph0 = pack4(32767, 0, 0, 0);
        repeat (3) begin
            @(posedge clk_data); #1;
            check("ct_ph1_hold", m_data, -250);
        end
        m_ready = 1'b1;
        @(posedge clk_data); #1;
        m_ready = 1'b0;
        $display("txn coeff_timing: ph1 used late-changed taps");

        // Randomized against the reference model
        do_reset();
        model_clear();
        for (int n = 0; n < 32; n++) begin
            if (n % 8 == 0) begin
                coeff_ph0 = {$urandom, $urandom};
                coeff_ph1 = {$urandom, $urandom};
            end
            smp = int'($signed(16'($urandom)));
            model_push(smp);
            e0 = ref_out(coeff_ph0);
            e1 = ref_out(coeff_ph1);
            send(smp, e0, e1, $urandom_range(0, 3), $urandom_range(0, 3),
                 $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
